multicycle_control: RTL and testbench

// Main control FSM for the multi-cycle CPU; the producer of the 3-bit ALUOp consumed by ALU control.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_ctrl_outdec.sv | 87 ++++++++
 rtl/multicycle_control.sv | 64 ++++++
 tb/tb_multicycle_control.sv | 127 ++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared widths, state encoding, opcode/funct constants and control word for the multi-cycle control FSM
package mc_ctrl_pkg;
    localparam int OP_W = 6;
    localparam int FN_W = 6;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_JREG   = 4'd13,
        S_TRAP   = 4'd14,
        S_BAD    = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_SUBI = 6'b001001;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [FN_W-1:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_ADDI = 3'b010;
    localparam logic [2:0] ALU_SUBI = 3'b011;
    localparam logic [2:0] ALU_RTYP = 3'b100;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    // Unqualified Moore control word; mem_ready/zero qualification happens in the top
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR fields, flags and memory handshake in; datapath control word out
//   master: the control FSM (drives controls), slave: the datapath (drives opcode/funct/zero/mem_ready)
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;
    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            mem_ready;
    logic            pc_en;
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_op;
    logic [1:0]      pc_source;
    logic            instr_done;
    logic            illegal;
    logic [ST_W-1:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, state
    );
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational decode of state (plus opcode for addi/subi) into the raw control word
//   i_state: current FSM state, i_opcode: IR opcode, o_cw: unqualified control word
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t          i_state,
    input  logic [OP_W-1:0] i_opcode,
    output ctrl_t           o_cw
);
    always_comb begin
        o_cw = '0;
        case (i_state)
            S_FETCH: begin
                o_cw.mem_read  = 1'b1;
                o_cw.ir_write  = 1'b1;
                o_cw.pc_write  = 1'b1;
                o_cw.alu_src_b = SRCB_4;
                o_cw.alu_op    = ALU_ADD;
                o_cw.pc_source = PCS_ALU;
            end
            S_DECODE: begin
                o_cw.alu_src_b = SRCB_IMM2;
                o_cw.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_IMM;
                o_cw.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                o_cw.mem_read = 1'b1;
                o_cw.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.mem_to_reg = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_cw.mem_write  = 1'b1;
                o_cw.iord       = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_RTEX: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_B;
                o_cw.alu_op    = ALU_RTYP;
            end
            S_RTWB: begin
                o_cw.reg_dst    = 1'b1;
                o_cw.reg_write  = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_cw.alu_src_a     = 1'b1;
                o_cw.alu_op        = ALU_SUB;
                o_cw.pc_write_cond = 1'b1;
                o_cw.pc_source     = PCS_ALUOUT;
                o_cw.instr_done    = 1'b1;
            end
            S_IMMEX: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_IMM;
                o_cw.alu_op    = (i_opcode == OP_SUBI) ? ALU_SUBI : ALU_ADDI;
            end
            S_IMMWB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_JUMP: begin
                o_cw.pc_write   = 1'b1;
                o_cw.pc_source  = PCS_JUMP;
                o_cw.instr_done = 1'b1;
            end
            S_JREG: begin
                o_cw.pc_write   = 1'b1;
                o_cw.pc_source  = PCS_REGA;
                o_cw.instr_done = 1'b1;
            end
            S_TRAP: begin
                o_cw.illegal    = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle CPU, sequencing fetch/decode/execute/writeback
//   clk, rst: clock and synchronous active-high reset
//   bus (master): opcode/funct/zero/mem_ready in; datapath enables, mux selects, alu_op, status out
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    state_t r_state;
    state_t w_next;
    ctrl_t  w_cw;
    logic   w_pc_write;

    mc_ctrl_outdec u_outdec (
        .i_state  (r_state),
        .i_opcode (bus.opcode),
        .o_cw     (w_cw)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                               (bus.opcode == OP_R) ? ((bus.funct == FN_JR) ? S_JREG : S_RTEX) :
                               (bus.opcode == OP_BEQ) ? S_BRANCH :
                               (bus.opcode == OP_ADDI || bus.opcode == OP_SUBI) ? S_IMMEX :
                               (bus.opcode == OP_J) ? S_JUMP : S_TRAP;
            S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   w_next = S_RTWB;
            S_IMMEX:  w_next = S_IMMWB;
            S_MEMWB, S_RTWB, S_BRANCH, S_IMMWB, S_JUMP, S_JREG, S_TRAP: w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // FETCH only commits IR/PC on the cycle memory delivers; MEMWR finishes only then too
    assign w_pc_write     = w_cw.pc_write & (r_state != S_FETCH || bus.mem_ready);
    assign bus.pc_en      = w_pc_write | (w_cw.pc_write_cond & bus.zero);
    assign bus.ir_write   = w_cw.ir_write & bus.mem_ready;
    assign bus.instr_done = w_cw.instr_done & (r_state != S_MEMWR || bus.mem_ready);
    assign bus.iord       = w_cw.iord;
    assign bus.mem_read   = w_cw.mem_read;
    assign bus.mem_write  = w_cw.mem_write;
    assign bus.reg_dst    = w_cw.reg_dst;
    assign bus.mem_to_reg = w_cw.mem_to_reg;
    assign bus.reg_write  = w_cw.reg_write;
    assign bus.alu_src_a  = w_cw.alu_src_a;
    assign bus.alu_src_b  = w_cw.alu_src_b;
    assign bus.alu_op     = w_cw.alu_op;
    assign bus.pc_source  = w_cw.pc_source;
    assign bus.illegal    = w_cw.illegal;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors pushed to a scoreboard, checked by a negedge monitor
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mc_ctrl_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [21:0] exp;
    } rec_t;

    rec_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   nid   = 0;
    bit   done  = 1'b0;

    // Expected outputs for a state, written straight from the per-state control table
    function automatic logic [17:0] exp_word(input logic [3:0] s, input logic [5:0] op,
                                             input logic z, input logic rd);
        logic pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, done_, ill;
        logic [1:0] sb, pcs;
        logic [2:0] aop;
        {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, done_, ill} = '0;
        sb = 2'b00; pcs = 2'b00; aop = 3'b000;
        case (s)
            4'd1:  begin mrd = 1; sb = 2'b01; irw = rd; pc_en = rd; end
            4'd2:  sb = 2'b11;
            4'd3:  begin sa = 1; sb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; done_ = 1; end
            4'd6:  begin mwr = 1; iord = 1; done_ = rd; end
            4'd7:  begin sa = 1; aop = 3'b100; end
            4'd8:  begin rdst = 1; rw = 1; done_ = 1; end
            4'd9:  begin sa = 1; aop = 3'b001; pcs = 2'b01; pc_en = z; done_ = 1; end
            4'd10: begin sa = 1; sb = 2'b10; aop = (op == 6'b001001) ? 3'b011 : 3'b010; end
            4'd11: begin rw = 1; done_ = 1; end
            4'd12: begin pc_en = 1; pcs = 2'b10; done_ = 1; end
            4'd13: begin pc_en = 1; pcs = 2'b11; done_ = 1; end
            4'd14: begin ill = 1; done_ = 1; end
            default: ;
        endcase
        return {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, pcs, done_, ill};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rd, input logic [3:0] s);
        rec_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus.opcode = op;
        bus.funct = fn;
        bus.zero = z;
        bus.mem_ready = rd;
        e.id = nid;
        e.exp = {exp_word(s, op, z, rd), s};
        nid++;
        q.push_back(e);
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n,
                       input logic [7:0] rdy, input logic [3:0] st [8]);
        for (int i = 0; i < n; i++) step(1'b0, op, fn, z, rdy[i], st[i]);
    endtask

    always @(negedge clk) begin
        logic [21:0] act;
        rec_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                   bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.pc_source, bus.instr_done, bus.illegal, bus.state};
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL vec%0d actual=%h required=%h", e.id, act, e.exp);
            end
        end
    end

    initial begin
        bus.opcode = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        step(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 4'd0);
        run(OP_LW, 6'd0, 1'b0, 5, 8'hFF, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0});
        run(OP_LW, 6'd0, 1'b0, 8, 8'b11111000, '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
        run(OP_SW, 6'd0, 1'b0, 4, 8'hFF, '{4'd1, 4'd2, 4'd3, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_SW, 6'd0, 1'b0, 5, 8'b11110111, '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd0, 4'd0, 4'd0});
        run(OP_R, 6'b100000, 1'b0, 4, 8'hFF, '{4'd1, 4'd2, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_R, FN_JR, 1'b0, 3, 8'hFF, '{4'd1, 4'd2, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_BEQ, 6'd0, 1'b1, 3, 8'hFF, '{4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_BEQ, 6'd0, 1'b0, 3, 8'hFF, '{4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_ADDI, 6'd0, 1'b0, 4, 8'hFF, '{4'd1, 4'd2, 4'd10, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_SUBI, 6'd0, 1'b0, 4, 8'hFF, '{4'd1, 4'd2, 4'd10, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_J, 6'd0, 1'b0, 3, 8'hFF, '{4'd1, 4'd2, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run(6'b111111, 6'd0, 1'b0, 3, 8'hFF, '{4'd1, 4'd2, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run(OP_LW, 6'd0, 1'b0, 5, 8'b00000111, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0});
        step(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 4'd4);
        step(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 4'd0);
        step(1'b0, OP_LW, 6'd0, 1'b0, 1'b0, 4'd0);
        run(OP_LW, 6'd0, 1'b0, 5, 8'hFF, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0});
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
